// File: rtl/rx_block_assembler_if.sv
// Purpose: receiver-word input bus, cipher-block output handshake and status bus for rx_block_assembler.
// Latency: none; this file only groups signals.
// Backpressure: blk_ready from the cipher core stalls the assembler's single output block buffer.
interface rx_block_assembler_if #(
    parameter int WORDS  = 4,
    parameter int WORD_W = 32,
    parameter int ERR_W  = 8
);
    // Receiver side
    logic                    Data_Ready;
    logic [WORD_W-1:0]       Data_Rx;
    logic                    parity_err;

    // Cipher core side
    logic                    blk_ready;
    logic                    blk_valid;
    logic [WORDS*WORD_W-1:0] blk_data;

    // Status
    logic [3:0]              word_cnt;
    logic                    drop_pulse;
    logic                    overrun;
    logic [ERR_W-1:0]        err_count;

    // Assembler view
    modport slave (
        input  Data_Ready, Data_Rx, parity_err, blk_ready,
        output blk_valid, blk_data, word_cnt, drop_pulse, overrun, err_count
    );

    // Environment view: drives the receiver words and the core's ready
    modport master (
        output Data_Ready, Data_Rx, parity_err, blk_ready,
        input  blk_valid, blk_data, word_cnt, drop_pulse, overrun, err_count
    );
endinterface

// File: rtl/rx_block_assembler.sv
// Purpose: packs WORDS good receiver words (first word in MS position) into one cipher block.
// Latency: block valid one cycle after the Data_Ready rising edge carrying its last word.
// Backpressure: one output block plus one held assembly block; further words are dropped and flag overrun.
module rx_block_assembler #(
    parameter int WORDS  = 4,
    parameter int WORD_W = 32,
    parameter int ERR_W  = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    rx_block_assembler_if.slave bus
);
    localparam int         BLK_W    = WORDS * WORD_W;
    localparam logic [3:0] LAST_CNT = 4'(WORDS - 1);
    localparam logic [3:0] FULL_CNT = 4'(WORDS);

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t            state;
    logic              data_ready_q;
    logic [BLK_W-1:0]  asm_q;
    logic [BLK_W-1:0]  blk_data_q;
    logic              blk_valid_q;
    logic [3:0]        word_cnt_q;
    logic              drop_pulse_q;
    logic              overrun_q;
    logic [ERR_W-1:0]  err_count_q;

    logic              we;
    logic              drain;
    logic              out_free;
    logic [BLK_W-1:0]  asm_shift;

    // Word event is the rising edge of Data_Ready; the level may be held indefinitely.
    assign we        = bus.Data_Ready & ~data_ready_q;
    assign drain     = blk_valid_q & bus.blk_ready;
    assign out_free  = ~blk_valid_q | bus.blk_ready;
    assign asm_shift = {asm_q[(WORDS-1)*WORD_W-1:0], bus.Data_Rx};

    // Assembly/output state machine; every output is a register.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state        <= COLLECT;
            data_ready_q <= 1'b0;
            asm_q        <= '0;
            blk_data_q   <= '0;
            blk_valid_q  <= 1'b0;
            word_cnt_q   <= 4'd0;
            drop_pulse_q <= 1'b0;
            overrun_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            data_ready_q <= bus.Data_Ready;
            drop_pulse_q <= 1'b0;
            case (state)
                COLLECT: begin
                    // Acceptance empties the output unless a completing word refills it below.
                    if (drain) begin
                        blk_valid_q <= 1'b0;
                    end
                    if (we) begin
                        if (bus.parity_err) begin
                            // Bad word: discard the partial block, never store the word.
                            asm_q        <= '0;
                            word_cnt_q   <= 4'd0;
                            drop_pulse_q <= 1'b1;
                            if (err_count_q != {ERR_W{1'b1}}) begin
                                err_count_q <= err_count_q + ERR_W'(1);
                            end
                        end else if (word_cnt_q == LAST_CNT) begin
                            if (out_free) begin
                                // Output is free (or being accepted now): hand the block over directly.
                                blk_data_q  <= asm_shift;
                                blk_valid_q <= 1'b1;
                                asm_q       <= '0;
                                word_cnt_q  <= 4'd0;
                            end else begin
                                // Output still occupied: park the finished block in assembly.
                                asm_q      <= asm_shift;
                                word_cnt_q <= FULL_CNT;
                                state      <= FULL;
                            end
                        end else begin
                            asm_q      <= asm_shift;
                            word_cnt_q <= word_cnt_q + 4'd1;
                        end
                    end
                end
                FULL: begin
                    // No room anywhere: any word arriving now is lost, even on the drain edge.
                    if (we) begin
                        overrun_q <= 1'b1;
                    end
                    // Parked block moves to the output on the same edge the old one is taken.
                    if (drain) begin
                        blk_data_q  <= asm_q;
                        blk_valid_q <= 1'b1;
                        asm_q       <= '0;
                        word_cnt_q  <= 4'd0;
                        state       <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign bus.blk_valid  = blk_valid_q;
    assign bus.blk_data   = blk_data_q;
    assign bus.word_cnt   = word_cnt_q;
    assign bus.drop_pulse = drop_pulse_q;
    assign bus.overrun    = overrun_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_rx_block_assembler.sv
// Purpose: scoreboard bench for rx_block_assembler with directed word sequences.
// Latency: expected blocks are queued at stimulus time and popped by a negedge monitor on each handshake.
// Backpressure: blk_ready is held low in the overrun and reset phases to exercise the buffers.
module tb_rx_block_assembler;
    localparam int WORDS  = 4;
    localparam int WORD_W = 32;
    localparam int ERR_W  = 8;
    localparam int BLK_W  = WORDS * WORD_W;

    logic CLK;
    logic CLR;
    int   n_tests;
    int   n_fail;
    logic [BLK_W-1:0] exp_q[$];

    rx_block_assembler_if #(.WORDS(WORDS), .WORD_W(WORD_W), .ERR_W(ERR_W)) bus ();

    rx_block_assembler #(.WORDS(WORDS), .WORD_W(WORD_W), .ERR_W(ERR_W)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] blk4(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic [31:0] d);
        return {a, b, c, d};
    endfunction

    // One receiver word: a low cycle, then a single high cycle carrying the word.
    task automatic send_word(input logic [31:0] data, input logic perr);
        bus.Data_Ready = 1'b0;
        @(posedge CLK); #1;
        bus.Data_Ready = 1'b1;
        bus.Data_Rx    = data;
        bus.parity_err = perr;
        @(posedge CLK); #1;
        bus.Data_Ready = 1'b0;
        bus.parity_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " blk_valid"},  BLK_W'(bus.blk_valid),  '0);
        chk({tag, " blk_data"},   bus.blk_data,           '0);
        chk({tag, " word_cnt"},   BLK_W'(bus.word_cnt),   '0);
        chk({tag, " drop_pulse"}, BLK_W'(bus.drop_pulse), '0);
        chk({tag, " overrun"},    BLK_W'(bus.overrun),    '0);
        chk({tag, " err_count"},  BLK_W'(bus.err_count),  '0);
    endtask

    // Monitor: every accepted block must match the oldest expected one.
    always @(negedge CLK) begin
        if (!CLR && bus.blk_valid && bus.blk_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_block: got %0h, expected no block", bus.blk_data);
            end else begin
                chk("blk_data", bus.blk_data, exp_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        CLR            = 1'b1;
        bus.Data_Ready = 1'b0;
        bus.Data_Rx    = '0;
        bus.parity_err = 1'b0;
        bus.blk_ready  = 1'b1;

        // Reset state
        #12;
        chk_all_zero("reset");
        #10;
        CLR = 1'b0;
        idle(2);

        // Basic block, one-cycle valid pulse
        exp_q.push_back(blk4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444));
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        chk("basic word_cnt=2", BLK_W'(bus.word_cnt), BLK_W'(2));
        send_word(32'h33333333, 1'b0);
        send_word(32'h44444444, 1'b0);
        chk("basic valid after 4th", BLK_W'(bus.blk_valid), BLK_W'(1));
        chk("basic word_cnt=0", BLK_W'(bus.word_cnt), '0);
        idle(1);
        chk("basic valid one cycle", BLK_W'(bus.blk_valid), '0);

        // Level-held Data_Ready counts once
        bus.Data_Ready = 1'b1;
        bus.Data_Rx    = 32'hDEADBEEF;
        idle(20);
        chk("level word_cnt", BLK_W'(bus.word_cnt), BLK_W'(1));
        bus.Data_Ready = 1'b0;
        exp_q.push_back(blk4(32'hDEADBEEF, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3));
        send_word(32'hA1A1A1A1, 1'b0);
        send_word(32'hA2A2A2A2, 1'b0);
        send_word(32'hA3A3A3A3, 1'b0);
        idle(2);

        // Parity drop
        send_word(32'hBAD00001, 1'b0);
        send_word(32'hBAD00002, 1'b0);
        send_word(32'hBAD00003, 1'b1);
        chk("parity word_cnt", BLK_W'(bus.word_cnt), '0);
        chk("parity drop_pulse hi", BLK_W'(bus.drop_pulse), BLK_W'(1));
        chk("parity err_count", BLK_W'(bus.err_count), BLK_W'(1));
        idle(1);
        chk("parity drop_pulse lo", BLK_W'(bus.drop_pulse), '0);
        exp_q.push_back(blk4(32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D));
        send_word(32'h0000000A, 1'b0);
        send_word(32'h0000000B, 1'b0);
        send_word(32'h0000000C, 1'b0);
        send_word(32'h0000000D, 1'b0);
        idle(2);

        // Backpressure and overrun
        bus.blk_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send_word(32'h1000_0000 + i, 1'b0);
        chk("bp blk_valid", BLK_W'(bus.blk_valid), BLK_W'(1));
        chk("bp held block1", bus.blk_data, blk4(32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004));
        chk("bp word_cnt full", BLK_W'(bus.word_cnt), BLK_W'(4));
        chk("bp overrun before", BLK_W'(bus.overrun), '0);
        send_word(32'h10000009, 1'b0);
        chk("bp overrun set", BLK_W'(bus.overrun), BLK_W'(1));
        chk("bp word_cnt after 9th", BLK_W'(bus.word_cnt), BLK_W'(4));
        chk("bp err_count untouched", BLK_W'(bus.err_count), BLK_W'(1));
        exp_q.push_back(blk4(32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004));
        exp_q.push_back(blk4(32'h10000005, 32'h10000006, 32'h10000007, 32'h10000008));
        bus.blk_ready = 1'b1;
        idle(1);
        chk("bp refill valid", BLK_W'(bus.blk_valid), BLK_W'(1));
        chk("bp refill word_cnt", BLK_W'(bus.word_cnt), '0);
        idle(1);
        chk("bp drained", BLK_W'(bus.blk_valid), '0);
        idle(2);
        chk("bp queue empty", BLK_W'(exp_q.size()), '0);

        // Saturation of err_count
        for (int i = 0; i < 300; i++) send_word(32'hE0000000 + i, 1'b1);
        chk("sat err_count", BLK_W'(bus.err_count), BLK_W'(255));
        chk("sat overrun sticky", BLK_W'(bus.overrun), BLK_W'(1));

        // Async reset mid-block with an unaccepted output block
        bus.blk_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send_word(32'h2000_0000 + i, 1'b0);
        chk("pre-reset valid", BLK_W'(bus.blk_valid), BLK_W'(1));
        chk("pre-reset word_cnt", BLK_W'(bus.word_cnt), BLK_W'(2));
        #3;
        CLR = 1'b1;
        #1;
        chk_all_zero("async reset");
        @(posedge CLK); #3;
        CLR = 1'b0;
        bus.blk_ready = 1'b1;
        idle(1);

        // Fresh block after reset carries no stale words
        exp_q.push_back(blk4(32'h30000001, 32'h30000002, 32'h30000003, 32'h30000004));
        for (int i = 1; i <= 4; i++) send_word(32'h3000_0000 + i, 1'b0);
        idle(3);
        chk("final queue empty", BLK_W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_block_assembler.md
Name: rx_block_assembler

Overview:
- Sits directly downstream of the serial receiver stage in the CRYPT link wrapper.
- Consumes that stage's 32-bit word outputs: Data_Rx, with Data_Ready and parity_err.
- Packs WORDS consecutive good words into one cipher block and hands the block to the cipher core over a valid/ready handshake.
- Provides one block of output buffering. Drops partial blocks on parity error and flags overruns.

Parameters:
- WORDS, 4: words per block; legal range 2..8.
- WORD_W, 32: receiver word width.
- ERR_W, 8: width of the saturating parity-drop counter.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- CLR  in  1  asynchronous, active-high reset.
- Data_Ready  in  1  receiver word-ready flag. May stay high for many cycles; only its rising edge counts.
- Data_Rx  in  WORD_W  received word; valid whenever Data_Ready is high.
- parity_err  in  1  parity status of the current word; sampled together with the Data_Ready rising edge.
- blk_ready  in  1  cipher core accepts the block.
- blk_valid  out  1  output block available.
- blk_data  out  WORDS*WORD_W  assembled block. First-received word sits in the MS word.
- word_cnt  out  4  number of words currently held in the assembly register.
- drop_pulse  out  1  one-cycle pulse when a partial block is discarded.
- overrun  out  1  sticky; a word was lost because both buffers were full.
- err_count  out  ERR_W  saturating count of parity drops.

Behaviour:
- Reset (async, CLR=1): all outputs go to 0. This covers blk_valid, blk_data, word_cnt, drop_pulse, overrun and err_count. Reset also clears the assembly register, the state (COLLECT) and the edge-detect register (Data_Ready_q=0).
  - Reset mid-block discards all data, including an unaccepted output block.
- Edge detect: word event we = Data_Ready & ~Data_Ready_q.
  - Data_Ready_q is registered every cycle.
  - If Data_Ready is high at the first clock after reset, that counts as an event.
- State COLLECT, on we with parity_err=0:
  - Shift Data_Rx into the assembly register: asm <= {asm[(WORDS-1)*WORD_W-1:0], Data_Rx}.
  - word_cnt increments.
- State COLLECT, on we with parity_err=1:
  - Assembly contents are discarded and word_cnt goes to 0.
  - drop_pulse goes high for exactly the next cycle.
  - err_count increments, saturating at all-ones.
  - The bad word is never stored.
- Block completion: a good word that brings the count to WORDS completes the block.
  - If the output is free in that cycle (blk_valid=0, or blk_valid&blk_ready), then on the next edge blk_data gets the completed block, blk_valid=1, word_cnt=0, and the state stays COLLECT.
  - Otherwise the state goes to FULL. word_cnt=WORDS and the block is held in assembly.
- State FULL:
  - When the output drains (blk_valid&blk_ready), the assembly block moves to the output on that same edge. blk_valid stays 1, word_cnt=0, state returns to COLLECT.
  - A we while in FULL (good or bad parity) sets overrun. The word is dropped; err_count and drop_pulse are unaffected.
  - If we coincides with the drain edge, the word is still dropped and overrun is set.
- Output handshake:
  - blk_data must hold stable while blk_valid=1 and blk_ready=0.
  - blk_valid falls on the edge after acceptance unless a refill happens on that edge.
  - Back-to-back acceptance sustains one block per WORDS receiver words with no bubble.
- Latency: a we that completes a block at cycle N (with the output free) gives blk_valid=1 at N+1.
- Simultaneous acceptance and completion in COLLECT: the new block replaces the accepted one on the same edge, and blk_valid stays 1.
- overrun clears only on CLR.

Test Plan:
- Basic block:
  - Stimulus: CLR pulse, then four Data_Ready rising edges with Data_Rx = 0x11111111, 0x22222222, 0x33333333, 0x44444444; parity_err=0; blk_ready=1.
  - Required: blk_valid for one cycle, starting the cycle after the 4th edge, with blk_data = 0x11111111_22222222_33333333_44444444.
- Level-held Data_Ready:
  - Stimulus: hold Data_Ready high for 20 cycles with Data_Rx=0xDEADBEEF.
  - Required: word_cnt=1 only; no further increments.
- Parity drop:
  - Stimulus: two good words, then a word with parity_err=1.
  - Required: word_cnt returns to 0, drop_pulse high for 1 cycle, err_count=1.
  - Then four good words A,B,C,D: blk_data={A,B,C,D}.
- Backpressure and overrun:
  - Stimulus: blk_ready=0; send 8 good words.
  - Required: blk_valid=1 holding block 1; word_cnt=4, state FULL.
  - A 9th word sets overrun=1. Raising blk_ready delivers block 1 and then block 2 on consecutive cycles; the 9th word never appears.
- Saturation and async reset:
  - Stimulus: 300 parity-error words with ERR_W=8.
  - Required: err_count=255.
  - Then assert CLR mid-block, between clock edges. Required: all outputs read 0 immediately, before the next clock edge.
